// File: rtl/mul_pkg.sv
// mul_pkg: shared constants and helpers for the tiled multiplier.
// Holds the legal parameter ranges, tile count and tile weight helpers.
package mul_pkg;

  localparam int W_MIN     = 8;
  localparam int W_MAX     = 64;
  localparam int TAG_W_MIN = 1;

  // Number of 8x8 tiles for a WxW product.
  function automatic int npp(input int w);
    return (w / 8) * (w / 8);
  endfunction

  // Bit weight of tile (i,j).
  function automatic int pp_shift(input int i, input int j);
    return 8 * (i + j);
  endfunction

endpackage

// File: rtl/mul8x8.sv
// mul8x8: unsigned 8x8 -> 16 multiply tile.
// Ports: a, b (8-bit operands), p (16-bit product).
module mul8x8 (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] p
);

  assign p = 16'(a) * 16'(b);

endmodule

// File: rtl/mul_pipe.sv
// mul_pipe: pipelined WxW signed/unsigned multiplier, valid/ready both sides.
// Ports: clk, rst, in_valid/in_ready/in_a/in_b/in_sgn/in_tag,
//        out_valid/out_ready/out_p/out_tag.
module mul_pipe
  import mul_pkg::*;
#(
  parameter int W       = 16,
  parameter int PIPE_PP = 1,
  parameter int TAG_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic             in_sgn,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*W-1:0]   out_p,
  output logic [TAG_W-1:0] out_tag
);

  localparam int N   = W / 8;
  localparam int NPP = npp(W);

  typedef logic [2*W-1:0] dw_t;

  if (W % 8 != 0 || W < W_MIN || W > W_MAX || TAG_W < TAG_W_MIN) begin : g_bad
    $error("mul_pipe: illegal W or TAG_W");
  end

  // S1
  logic             v1;
  logic [W-1:0]     a1;
  logic [W-1:0]     b1;
  logic             sgn1;
  logic [TAG_W-1:0] tag1;

  // S2 view as seen by S3 (registered or pass-through)
  logic             v2;
  logic [TAG_W-1:0] tag2;
  dw_t              corr2;
  logic [15:0]      pp2 [NPP];

  logic [15:0]      pp1 [NPP];
  dw_t              corr1;

  logic             ld1;
  logic             ld3;
  logic             v3;

  assign ld3       = !v3 || out_ready;
  assign in_ready  = ld1;
  assign out_valid = v3;

  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
    end else if (ld1) begin
      v1 <= in_valid;
      if (in_valid) begin
        a1   <= in_a;
        b1   <= in_b;
        sgn1 <= in_sgn;
        tag1 <= in_tag;
      end
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      mul8x8 u_tile (
        .a (a1[8*i +: 8]),
        .b (b1[8*j +: 8]),
        .p (pp1[i*N + j])
      );
    end
  end

  // Two's-complement fix-up: a negative operand contributes an extra
  // 2^W times the other operand in the unsigned product.
  always_comb begin
    corr1 = '0;
    if (sgn1 && a1[W-1]) corr1 = corr1 + (dw_t'(b1) << W);
    if (sgn1 && b1[W-1]) corr1 = corr1 + (dw_t'(a1) << W);
  end

  if (PIPE_PP != 0) begin : g_s2
    logic ld2;

    assign ld2 = !v2 || ld3;
    assign ld1 = !v1 || ld2;

    always_ff @(posedge clk) begin
      if (rst) begin
        v2 <= 1'b0;
      end else if (ld2) begin
        v2 <= v1;
        if (v1) begin
          tag2  <= tag1;
          corr2 <= corr1;
          pp2   <= pp1;
        end
      end
    end
  end else begin : g_s2
    assign ld1   = !v1 || ld3;
    assign v2    = v1;
    assign tag2  = tag1;
    assign corr2 = corr1;
    assign pp2   = pp1;
  end

  // Tile reduction: running sum, each tile at weight 2^(8(i+j)).
  dw_t acc [NPP+1];
  assign acc[0] = '0;

  for (genvar k = 0; k < NPP; k++) begin : g_red
    localparam int I = k / N;
    localparam int J = k % N;
    assign acc[k+1] = acc[k] + (dw_t'(pp2[k]) << pp_shift(I, J));
  end

  dw_t prod;
  assign prod = acc[NPP] - corr2;

  always_ff @(posedge clk) begin
    if (rst) begin
      v3      <= 1'b0;
      out_p   <= '0;
      out_tag <= '0;
    end else if (ld3) begin
      v3 <= v2;
      if (v2) begin
        out_p   <= prod;
        out_tag <= tag2;
      end
    end
  end

endmodule

// File: tb/tb_mul_pipe.sv
// tb_mul_pipe: scoreboard bench for mul_pipe plus a width/pipe sweep.
// Main DUT W=16 PIPE_PP=1; six extra instances cover W=8/32/64.
module tb_mul_pipe;

  localparam int W  = 16;
  localparam int TW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic          in_sgn;
  logic [TW-1:0] in_tag;
  logic          out_valid;
  logic          out_ready;
  logic [2*W-1:0] out_p;
  logic [TW-1:0] out_tag;

  always #5 clk = ~clk;

  mul_pipe #(.W(W), .PIPE_PP(1), .TAG_W(TW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_sgn    (in_sgn),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p),
    .out_tag   (out_tag)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    else
      n_pass++;
  endtask

  // Reference: sign/zero-extend to 128 bits, multiply, keep 2w bits.
  function automatic logic [127:0] ref_mul(input logic [63:0] a,
                                           input logic [63:0] b,
                                           input logic s, input int w);
    logic [127:0] m, ea, eb, r;
    m  = (128'(1) << w) - 128'(1);
    ea = 128'(a) & m;
    eb = 128'(b) & m;
    if (s && a[w-1]) ea = ea | ~m;
    if (s && b[w-1]) eb = eb | ~m;
    r = ea * eb;
    return r & ((128'(1) << (2*w)) - 128'(1));
  endfunction

  typedef struct {
    logic [31:0] p;
    logic [3:0]  tag;
    int          cyc;
  } sb_t;

  sb_t         q[$];
  sb_t         mon_e;
  logic [31:0] cur_exp;
  int          cyc = 0;
  int          n_acc = 0;
  int          n_out = 0;
  bit          lat_on = 0;
  bit          rand_rdy = 0;
  bit          sweep_go = 0;
  int          sweep_done = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: negedge sees the handshake for the coming posedge.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (out_valid && out_ready) begin
        n_out++;
        if (q.size() == 0) begin
          chk("extra_out", 128'(q.size()), 128'(1));
        end else begin
          mon_e = q.pop_front();
          chk("prod", 128'(out_p), 128'(mon_e.p));
          chk("tag", 128'(out_tag), 128'(mon_e.tag));
          if (lat_on) chk("lat", 128'(cyc - mon_e.cyc), 128'(3));
        end
      end
      if (in_valid && in_ready) begin
        q.push_back('{cur_exp, in_tag, cyc});
        n_acc++;
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] a, input logic [15:0] b,
                      input logic s, input logic [3:0] t,
                      input logic [31:0] e, input int bound,
                      output bit ok);
    in_a     = a;
    in_b     = b;
    in_sgn   = s;
    in_tag   = t;
    cur_exp  = e;
    in_valid = 1'b1;
    ok       = 1'b0;
    for (int k = 0; k < bound && !ok; k++) begin
      @(negedge clk);
      ok = in_ready;
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic put(input logic [15:0] a, input logic [15:0] b,
                     input logic s, input logic [3:0] t,
                     input logic [31:0] e);
    bit ok;
    send(a, b, s, t, e, 64, ok);
    chk("accept", 128'(ok), 128'(1));
  endtask

  task automatic drain();
    for (int k = 0; k < 60 && q.size() > 0; k++) step();
    chk("drain", 128'(q.size()), 128'(0));
  endtask

  // Width / pipe-depth sweep instances.
  for (genvar g = 0; g < 6; g++) begin : g_sw
    localparam int SW = (g < 2) ? 8 : ((g < 4) ? 32 : 64);
    localparam int SP = g % 2;

    logic            sv, sr, ss, ov;
    logic [SW-1:0]   sa, sb;
    logic [3:0]      ot;
    logic [2*SW-1:0] op;

    mul_pipe #(.W(SW), .PIPE_PP(SP), .TAG_W(4)) u_sw (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (sv),
      .in_ready  (sr),
      .in_a      (sa),
      .in_b      (sb),
      .in_sgn    (ss),
      .in_tag    (4'(g)),
      .out_valid (ov),
      .out_ready (1'b1),
      .out_p     (op),
      .out_tag   (ot)
    );

    initial begin
      logic [63:0]  ta, tb;
      logic [127:0] ex;
      int           lat;
      bit           acc, ts;
      sv = 1'b0;
      sa = '0;
      sb = '0;
      ss = 1'b0;
      wait (sweep_go);
      for (int t = 0; t < 3; t++) begin
        ta = '1;
        tb = '1;
        ts = (t == 0);
        if (t == 2) begin
          ta = {$urandom, $urandom};
          tb = {$urandom, $urandom};
          ts = 1'($urandom_range(0, 1));
        end
        if (t == 0)
          ex = 128'(1);
        else if (t == 1)
          ex = (128'(1) << (2*SW)) - (128'(1) << (SW+1)) + 128'(1);
        else
          ex = ref_mul(ta, tb, ts, SW);
        step();
        sa = SW'(ta);
        sb = SW'(tb);
        ss = ts;
        sv = 1'b1;
        @(negedge clk);
        acc = sr;
        step();
        sv  = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!ov && lat < 10) begin
          @(negedge clk);
          lat++;
        end
        chk($sformatf("sw%0d_acc", g), 128'(acc), 128'(1));
        chk($sformatf("sw%0d_lat", g), 128'(lat), 128'(2 + SP));
        chk($sformatf("sw%0d_p%0d", g, t), 128'(op), ex);
        chk($sformatf("sw%0d_tag", g), 128'(ot), 128'(g));
      end
      sweep_done++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          ok;
    int          a0, o0;
    logic [15:0] ra, rb;
    logic        rs;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_sgn    = 1'b0;
    in_tag    = '0;
    out_ready = 1'b0;
    cur_exp   = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("rst_ov", 128'(out_valid), 128'(0));
    chk("rst_p", 128'(out_p), 128'(0));
    chk("rst_tag", 128'(out_tag), 128'(0));
    chk("rst_rdy", 128'(in_ready), 128'(1));
    step();

    // Directed products, latency checked.
    out_ready = 1'b1;
    lat_on    = 1'b1;
    put(16'hFFFF, 16'hFFFF, 1'b0, 4'd1, 32'hFFFE0001);
    put(16'hFFFF, 16'hFFFF, 1'b1, 4'd2, 32'h00000001);
    put(16'h8000, 16'h8000, 1'b1, 4'd3, 32'h40000000);
    put(16'h8000, 16'h0002, 1'b1, 4'd4, 32'hFFFF0000);
    put(16'h8000, 16'h0002, 1'b0, 4'd5, 32'h00010000);
    drain();
    lat_on = 1'b0;

    // Back-pressure: three fit, the fourth waits.
    out_ready = 1'b0;
    a0 = n_acc;
    o0 = n_out;
    for (int k = 1; k <= 3; k++)
      put(16'(k * 16'h0111), 16'(k + 2), 1'b0, 4'(k),
          32'(ref_mul(64'(k * 16'h0111), 64'(k + 2), 1'b0, 16)));
    send(16'h0444, 16'd6, 1'b0, 4'd4,
         32'(ref_mul(64'h0444, 64'd6, 1'b0, 16)), 6, ok);
    chk("bp_held", 128'(ok), 128'(0));
    chk("bp_acc", 128'(n_acc - a0), 128'(3));
    @(negedge clk);
    chk("bp_rdy", 128'(in_ready), 128'(0));
    step();
    out_ready = 1'b1;
    for (int k = 4; k <= 5; k++)
      put(16'(k * 16'h0111), 16'(k + 2), 1'b0, 4'(k),
          32'(ref_mul(64'(k * 16'h0111), 64'(k + 2), 1'b0, 16)));
    drain();
    chk("bp_out", 128'(n_out - o0), 128'(5));

    // Bubbles with random back-pressure.
    rand_rdy = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rs = 1'($urandom_range(0, 1));
      step();
      put(ra, rb, rs, 4'(i), 32'(ref_mul(64'(ra), 64'(rb), rs, 16)));
    end
    rand_rdy  = 1'b0;
    out_ready = 1'b1;
    drain();

    // Reset with three in flight.
    out_ready = 1'b0;
    put(16'h1234, 16'h0011, 1'b0, 4'd6, 32'h00013574);
    put(16'h0101, 16'h0101, 1'b0, 4'd7, 32'h00010201);
    put(16'h00FF, 16'h0002, 1'b0, 4'd8, 32'h000001FE);
    rst = 1'b1;
    q.delete();
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_ov", 128'(out_valid), 128'(0));
    chk("mrst_p", 128'(out_p), 128'(0));
    chk("mrst_rdy", 128'(in_ready), 128'(1));
    step();
    o0        = n_out;
    out_ready = 1'b1;
    lat_on    = 1'b1;
    put(16'h0003, 16'h0005, 1'b0, 4'd9, 32'h0000000F);
    drain();
    lat_on = 1'b0;
    repeat (4) step();
    chk("mrst_out", 128'(n_out - o0), 128'(1));

    // Width sweep.
    sweep_go = 1'b1;
    for (int k = 0; k < 300 && sweep_done < 6; k++) step();
    chk("sweep_done", 128'(sweep_done), 128'(6));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
